simd_booth_sequencer: RTL and testbench



---
 rtl/simd_booth_pkg.sv | 48 ++++
 rtl/booth_lane_recode.sv | 26 ++
 rtl/simd_booth_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_simd_booth_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_booth_pkg.sv
// -----------------------------------------------------------------------------
// simd_booth_pkg
// Shared definitions for the SIMD Booth multiplier sequencer:
//   - mode encodings (one 16-bit, two 8-bit or four 4-bit signed lanes)
//   - lane / register geometry
//   - iteration count per mode
//   - sequencer FSM state encodings
// -----------------------------------------------------------------------------
package simd_booth_pkg;

    // Lane-mode encodings, shared with the downstream adder/subtractor.
    localparam logic [1:0] MODE_16  = 2'b00;
    localparam logic [1:0] MODE_8   = 2'b01;
    localparam logic [1:0] MODE_4   = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    // Recoding is done at nibble granularity; wider lanes replicate the
    // Booth pair across the nibbles they own.
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NUM_NIB = 4;

    // Partial-product register width: four 4-bit lanes of {A, Q, q-1}.
    localparam int unsigned Z_W = 36;

    // Iterations per mode equal the lane width.
    localparam logic [4:0] ITER_16 = 5'd16;
    localparam logic [4:0] ITER_8  = 5'd8;
    localparam logic [4:0] ITER_4  = 5'd4;

    // Sequencer FSM states.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Number of Booth iterations for a given mode (0 for the illegal mode).
    function automatic logic [4:0] iter_count(input logic [1:0] m);
        logic [4:0] n;
        case (m)
            MODE_16: n = ITER_16;
            MODE_8:  n = ITER_8;
            MODE_4:  n = ITER_4;
            default: n = 5'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/booth_lane_recode.sv
// -----------------------------------------------------------------------------
// booth_lane_recode
// Radix-2 Booth recoder for one multiplicand slice.
//   q0      : current multiplier LSB of the owning lane
//   q_m1    : previously shifted-out multiplier bit (q-1) of the owning lane
//   m_lane  : multiplicand slice
//   flag    : 1 = subtract, 0 = add (or no-op)
//   m_gated : multiplicand slice for add/subtract, zero for a Booth no-op
// -----------------------------------------------------------------------------
module booth_lane_recode
    import simd_booth_pkg::*;
#(
    parameter int unsigned W = NIB_W
) (
    input  logic         q0,
    input  logic         q_m1,
    input  logic [W-1:0] m_lane,
    output logic         flag,
    output logic [W-1:0] m_gated
);

    // Pair 10 subtracts, 01 adds, 00/11 pass A through unchanged (add 0).
    assign flag    = q0 & ~q_m1;
    assign m_gated = (q0 ^ q_m1) ? m_lane : '0;

endmodule

// File: rtl/simd_booth_sequencer.sv
// -----------------------------------------------------------------------------
// simd_booth_sequencer
// Iterative Booth control/datapath stage in front of the SIMD adder/subtractor.
// Owns the 36-bit Z partial-product register, recodes each lane's Booth pair,
// takes back the combinational sum, arithmetic-right-shifts each lane and
// sequences one 16x16, two 8x8 or four 4x4 signed multiplies.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   start        request; accepted only in IDLE with mode_in != 2'b11
//   mode_in      00 = 1x16, 01 = 2x8, 10 = 4x4, 11 = illegal
//   multiplicand packed signed lanes
//   multiplier   packed signed lanes
//   mode         latched mode, to the adder/subtractor
//   Z            partial-product register, to the adder/subtractor
//   M_out        per-lane multiplicand, or 0 for a Booth no-op
//   flags        per-nibble subtract flags
//   sum          adder/subtractor result for the current Z/M_out/flags
//   busy         high while iterating
//   done         one-cycle pulse when product becomes valid
//   product      packed lane products, lane k at [2w(k+1)-1 : 2wk]
// -----------------------------------------------------------------------------
module simd_booth_sequencer
    import simd_booth_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      mode_in,
    input  logic [15:0]     multiplicand,
    input  logic [15:0]     multiplier,
    output logic [1:0]      mode,
    output logic [Z_W-1:0]  Z,
    output logic [15:0]     M_out,
    output logic [3:0]      flags,
    input  logic [15:0]     sum,
    output logic            busy,
    output logic            done,
    output logic [31:0]     product
);

    state_t               state;
    logic [4:0]           count;
    logic [1:0]           mode_q;
    logic [15:0]          mcand_q;
    logic [Z_W-1:0]       z_q;
    logic [31:0]          product_q;

    logic [NUM_NIB-1:0]   q0_nib;
    logic [NUM_NIB-1:0]   qm1_nib;
    logic [NUM_NIB-1:0]   flag_nib;
    logic [15:0]          m_nib;

    logic [Z_W-1:0]       z_load;
    logic [Z_W-1:0]       z_shift;
    logic [31:0]          prod_pack;

    // -------------------------------------------------------------------------
    // Booth pair per nibble. Each nibble gets the pair of the lane that owns
    // it. Outside RUN the pair is forced to 00, which zeroes M_out and flags.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned and a latch is never inferred.
        q0_nib  = '0;
        qm1_nib = '0;
        if (state == RUN) begin
            case (mode_q)
                MODE_16: begin
                    q0_nib  = {4{z_q[1]}};
                    qm1_nib = {4{z_q[0]}};
                end
                MODE_8: begin
                    q0_nib  = {{2{z_q[18]}}, {2{z_q[1]}}};
                    qm1_nib = {{2{z_q[17]}}, {2{z_q[0]}}};
                end
                MODE_4: begin
                    for (int k = 0; k < 4; k++) begin
                        q0_nib[k]  = z_q[9*k + 1];
                        qm1_nib[k] = z_q[9*k];
                    end
                end
                default: begin
                    q0_nib  = '0;
                    qm1_nib = '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_NIB; g++) begin : g_recode
        booth_lane_recode #(
            .W (NIB_W)
        ) u_recode (
            .q0      (q0_nib[g]),
            .q_m1    (qm1_nib[g]),
            .m_lane  (mcand_q[NIB_W*g +: NIB_W]),
            .flag    (flag_nib[g]),
            .m_gated (m_nib[NIB_W*g +: NIB_W])
        );
    end

    // -------------------------------------------------------------------------
    // Initial lane image: A = 0, Q = multiplier lane, q-1 = 0. Unused top
    // bits of Z stay zero in the wider modes.
    // -------------------------------------------------------------------------
    always_comb begin
        z_load = '0;
        case (mode_in)
            MODE_16: z_load = {3'b0, 16'b0, multiplier, 1'b0};
            MODE_8:  z_load = {2'b0, 8'b0, multiplier[15:8], 1'b0,
                               8'b0, multiplier[7:0], 1'b0};
            MODE_4: begin
                for (int k = 0; k < 4; k++)
                    z_load[9*k +: 9] = {4'b0, multiplier[4*k +: 4], 1'b0};
            end
            default: z_load = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // One iteration: each lane becomes asr({sum slice, Q, q-1}, 1). The sum
    // slice's sign bit is replicated inside its own lane only, so nothing
    // crosses a lane boundary.
    // -------------------------------------------------------------------------
    always_comb begin
        z_shift = z_q;
        case (mode_q)
            MODE_16: z_shift = {3'b0, sum[15], sum, z_q[16:1]};
            MODE_8: begin
                z_shift[35:34] = 2'b0;
                z_shift[33:17] = {sum[15], sum[15:8], z_q[25:18]};
                z_shift[16:0]  = {sum[7],  sum[7:0],  z_q[8:1]};
            end
            MODE_4: begin
                for (int k = 0; k < 4; k++)
                    z_shift[9*k +: 9] = {sum[4*k + 3], sum[4*k +: 4],
                                         z_q[9*k + 1 +: 4]};
            end
            default: z_shift = z_q;
        endcase
    end

    // Packed product taken from the final shifted lanes ({A, Q} per lane).
    always_comb begin
        prod_pack = '0;
        case (mode_q)
            MODE_16: prod_pack = z_shift[32:1];
            MODE_8:  prod_pack = {z_shift[33:18], z_shift[16:1]};
            MODE_4: begin
                for (int k = 0; k < 4; k++)
                    prod_pack[8*k +: 8] = z_shift[9*k + 1 +: 8];
            end
            default: prod_pack = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer. The multiplicand is captured with the request so operand
    // changes during RUN cannot disturb an operation in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            mode_q    <= '0;
            mcand_q   <= '0;
            z_q       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (mode_in != MODE_ILL)) begin
                        mode_q  <= mode_in;
                        mcand_q <= multiplicand;
                        z_q     <= z_load;
                        count   <= iter_count(mode_in);
                        state   <= RUN;
                    end
                end
                RUN: begin
                    z_q   <= z_shift;
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        product_q <= prod_pack;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mode    = mode_q;
    assign Z       = z_q;
    assign M_out   = m_nib;
    assign flags   = flag_nib;
    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_simd_booth_sequencer.sv
// -----------------------------------------------------------------------------
// tb_simd_booth_sequencer
// Directed bench for simd_booth_sequencer. A behavioural lane-split
// adder/subtractor closes the sum loop; expected products come from direct
// signed multiplication per lane and are queued when a request is issued.
// -----------------------------------------------------------------------------
module tb_simd_booth_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode_in;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [1:0]  mode;
    logic [35:0] Z;
    logic [15:0] M_out;
    logic [3:0]  flags;
    logic [15:0] sum;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int          n_cmp;
    int          n_fail;
    int          done_cnt;
    logic [31:0] sb[$];

    simd_booth_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode_in      (mode_in),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mode         (mode),
        .Z            (Z),
        .M_out        (M_out),
        .flags        (flags),
        .sum          (sum),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Downstream SIMD adder/subtractor: independent per-lane add or subtract.
    function automatic logic [15:0] adder_model(input logic [1:0] m,
                                                input logic [35:0] z,
                                                input logic [15:0] mo,
                                                input logic [3:0] f);
        logic [15:0] s;
        logic [3:0]  a4;
        s = '0;
        case (m)
            2'b00: s = f[0] ? z[32:17] - mo : z[32:17] + mo;
            2'b01: begin
                s[15:8] = f[2] ? z[33:26] - mo[15:8] : z[33:26] + mo[15:8];
                s[7:0]  = f[0] ? z[16:9]  - mo[7:0]  : z[16:9]  + mo[7:0];
            end
            2'b10: begin
                for (int k = 0; k < 4; k++) begin
                    a4 = z[9*k + 5 +: 4];
                    s[4*k +: 4] = f[k] ? a4 - mo[4*k +: 4] : a4 + mo[4*k +: 4];
                end
            end
            default: s = '0;
        endcase
        return s;
    endfunction

    assign sum = adder_model(mode, Z, M_out, flags);

    // Reference: signed multiply of each lane, packed at twice the lane width.
    function automatic logic [31:0] ref_product(input logic [1:0] m,
                                                input logic [15:0] mc,
                                                input logic [15:0] mp);
        logic [31:0] r;
        logic [7:0]  x8, y8;
        logic [3:0]  x4, y4;
        int          p;
        r = '0;
        case (m)
            2'b00: begin
                p = int'($signed(mc)) * int'($signed(mp));
                r = p;
            end
            2'b01: begin
                for (int k = 0; k < 2; k++) begin
                    x8 = mc[8*k +: 8];
                    y8 = mp[8*k +: 8];
                    p  = int'($signed(x8)) * int'($signed(y8));
                    r[16*k +: 16] = p[15:0];
                end
            end
            2'b10: begin
                for (int k = 0; k < 4; k++) begin
                    x4 = mc[4*k +: 4];
                    y4 = mp[4*k +: 4];
                    p  = int'($signed(x4)) * int'($signed(y4));
                    r[8*k +: 8] = p[7:0];
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Replace multiplicand lanes equal to -2^(w-1), whose result is undefined.
    function automatic logic [15:0] legal_mcand(input logic [1:0] m,
                                                input logic [15:0] mc);
        logic [15:0] r;
        r = mc;
        case (m)
            2'b00: if (r == 16'h8000) r = 16'h7FFF;
            2'b01: begin
                if (r[15:8] == 8'h80) r[15:8] = 8'h7F;
                if (r[7:0]  == 8'h80) r[7:0]  = 8'h7F;
            end
            default: begin
                for (int k = 0; k < 4; k++)
                    if (r[4*k +: 4] == 4'h8) r[4*k +: 4] = 4'h7;
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle request; legal requests queue their expected product.
    task automatic start_op(input logic [1:0] m, input logic [15:0] mc,
                            input logic [15:0] mp);
        mode_in      = m;
        multiplicand = mc;
        multiplier   = mp;
        start        = 1'b1;
        if (m != 2'b11) sb.push_back(ref_product(m, mc, mp));
        tick();
        start = 1'b0;
    endtask

    // Called while sampling cycle 'elapsed' after the start edge (cycle 1 is
    // the one right after it). Expects done in cycle w+1 and busy for w cycles.
    task automatic wait_done(input string tag, input int w, input int elapsed);
        int          cyc;
        int          busy_cyc;
        int          cnt0;
        logic [31:0] exp;
        cyc      = elapsed;
        busy_cyc = elapsed - 1;
        cnt0     = done_cnt;
        while (done !== 1'b1 && cyc < elapsed + 100) begin
            if (busy === 1'b1) busy_cyc++;
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(w + 1));
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(w));
        exp = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_product"}, 64'(product), 64'(exp));
        check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        tick();
        check({tag, "_done_pulse_width"}, 64'(done), 64'd0);
        check({tag, "_done_count"}, 64'(done_cnt), 64'(cnt0 + 1));
    endtask

    initial begin
        logic [1:0]  rm;
        logic [15:0] rmc;
        logic [15:0] rmp;
        int          snap;

        n_cmp        = 0;
        n_fail       = 0;
        done_cnt     = 0;
        rst          = 1'b1;
        start        = 1'b0;
        mode_in      = 2'b00;
        multiplicand = '0;
        multiplier   = '0;

        // ---- reset state ----
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_done",    64'(done),    64'd0);
        check("rst_Z",       64'(Z),       64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_mode",    64'(mode),    64'd0);
        check("rst_M_out",   64'(M_out),   64'd0);
        check("rst_flags",   64'(flags),   64'd0);

        // ---- mode 00: 3 x -5 ----
        start_op(2'b00, 16'h0003, 16'hFFFB);
        check("m16_busy_c1", 64'(busy),  64'd1);
        check("m16_mode",    64'(mode),  64'd0);
        check("m16_Z_load",  64'(Z),     64'h0_0001_FFF6);
        check("m16_flags",   64'(flags), 64'hF);
        check("m16_M_out",   64'(M_out), 64'h0003);
        wait_done("m16", 16, 1);
        check("m16_value", 64'(product), 64'hFFFF_FFF1);

        // ---- mode 01: 7 x -3, 127 x 127 ----
        start_op(2'b01, 16'h077F, 16'hFD7F);
        check("m8_mode",   64'(mode), 64'd1);
        check("m8_Z_load", 64'(Z),    64'h0_03F4_00FE);
        wait_done("m8", 8, 1);
        check("m8_value", 64'(product), 64'hFFEB_3F01);

        // ---- mode 10: four independent 4x4 lanes ----
        start_op(2'b10, 16'h3E71, 16'h5380);
        check("m4_Z_load", 64'(Z),     64'h0_5018_2000);
        check("m4_flags",  64'(flags), 64'b1100);
        check("m4_M_out",  64'(M_out), 64'h3E00);
        wait_done("m4", 4, 1);
        check("m4_value", 64'(product), 64'h0FFA_C800);
        check("idle_M_out", 64'(M_out), 64'd0);
        check("idle_flags", 64'(flags), 64'd0);

        // ---- start during RUN is ignored; operands change under it ----
        start_op(2'b01, 16'h2B9D, 16'h6C3E);
        tick();
        tick();
        mode_in      = 2'b00;
        multiplicand = 16'h1111;
        multiplier   = 16'h2222;
        start        = 1'b1;
        tick();
        start = 1'b0;
        check("ovl_busy", 64'(busy), 64'd1);
        check("ovl_mode", 64'(mode), 64'd1);
        wait_done("ovl", 8, 4);

        // ---- illegal mode start in IDLE is ignored ----
        snap = done_cnt;
        start_op(2'b11, 16'h1234, 16'h5678);
        check("ill_busy", 64'(busy), 64'd0);
        check("ill_done", 64'(done), 64'd0);
        check("ill_mode", 64'(mode), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        check("ill_busy_later", 64'(busy), 64'd0);
        check("ill_no_done", 64'(done_cnt), 64'(snap));

        // ---- reset at iteration 5 of a mode 00 op aborts it ----
        snap = done_cnt;
        start_op(2'b00, 16'h1234, 16'h0567);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("abort_busy",    64'(busy),    64'd0);
        check("abort_done",    64'(done),    64'd0);
        check("abort_Z",       64'(Z),       64'd0);
        check("abort_product", 64'(product), 64'd0);
        for (int i = 0; i < 20; i++) tick();
        check("abort_no_done", 64'(done_cnt), 64'(snap));
        start_op(2'b00, 16'h0002, 16'h0002);
        wait_done("after_abort", 16, 1);
        check("after_abort_value", 64'(product), 64'h0000_0004);

        // ---- multiplier lane at the most negative value ----
        start_op(2'b00, 16'h7FFF, 16'h8000);
        wait_done("mp_min16", 16, 1);
        check("mp_min16_value", 64'(product), 64'hC000_8000);
        start_op(2'b01, 16'h8105, 16'h8080);
        wait_done("mp_min8", 8, 1);

        // ---- a few random operations across the legal modes ----
        for (int i = 0; i < 6; i++) begin
            rm  = 2'($urandom_range(0, 2));
            rmc = legal_mcand(rm, 16'($urandom));
            rmp = 16'($urandom);
            start_op(rm, rmc, rmp);
            wait_done("rand", (rm == 2'b00) ? 16 : (rm == 2'b01) ? 8 : 4, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
